// File: rtl/lsu_dmem.sv
// lsu_dmem: load/store unit with a private, word-organised, little-endian
// data memory. Each request passes through IDLE -> ACCESS -> RESP, so a new
// request can be accepted at most once every three cycles. A store that
// completes is therefore always visible to the next load.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_valid_i     request present
//   req_ready_o     high only in IDLE; accept = req_valid_i && req_ready_o
//   memren_i        load request
//   memwren_i       store request
//   funct3_i        RV32I load/store funct3 (size and signedness)
//   addr_i          byte address
//   wdata_i         store data; low bytes used for SB/SH
//   rsp_valid_o     one-cycle response strobe (RESP state)
//   rdata_o         extended load result; 0 for stores and faults
//   fault_o         request rejected, qualified by rsp_valid_o
//   busy_o          a request is in flight
module lsu_dmem #(
  parameter int                DWIDTH      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [DWIDTH-1:0] BASE_ADDR   = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              memren_i,
  input  logic              memwren_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic              rsp_valid_o,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              fault_o,
  output logic              busy_o
);

  localparam int                IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [DWIDTH-1:0] DEPTH_L = DWIDTH'(DEPTH_WORDS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // Select the addressed byte/halfword and extend it according to funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = word;
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [1:0]        state;
  logic              accept;

  logic              ren_p0;
  logic              wren_p0;
  logic [2:0]        funct3_p0;
  logic [DWIDTH-1:0] addr_p0;
  logic [DWIDTH-1:0] wdata_p0;

  logic [DWIDTH-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic              range_bad;
  logic              f3_bad;
  logic              misalign;
  logic              access_fault;
  logic [3:0]        byte_en;
  logic [DWIDTH-1:0] wlane;
  logic [DWIDTH-1:0] word_rd;
  logic              fault_p1;

  logic [DWIDTH-1:0] mem [DEPTH_WORDS];

  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign busy_o      = (state != IDLE);
  assign rsp_valid_o = (state == RESP);
  assign fault_o     = (state == RESP) && fault_p1;

  // Request capture (IDLE -> ACCESS); inputs outside an accept are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      ren_p0    <= memren_i;
      wren_p0   <= memwren_i;
      funct3_p0 <= funct3_i;
      addr_p0   <= addr_i;
      wdata_p0  <= wdata_i;
    end
  end

  // Decode of the captured request, evaluated during ACCESS.
  always_comb begin
    offset    = addr_p0 - BASE_ADDR;
    range_bad = (addr_p0 < BASE_ADDR) || ((offset >> 2) >= DEPTH_L);
    idx       = offset[IDX_W+1:2];
    word_rd   = mem[idx];

    f3_bad = 1'b0;
    if (ren_p0 && !(funct3_p0 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
      f3_bad = 1'b1;
    if (wren_p0 && !(funct3_p0 inside {3'd0, 3'd1, 3'd2}))
      f3_bad = 1'b1;

    // funct3[1:0] encodes size for both loads and stores.
    misalign = 1'b0;
    case (funct3_p0[1:0])
      2'b01:   misalign = addr_p0[0];
      2'b10:   misalign = (addr_p0[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase

    access_fault = (ren_p0 == wren_p0) || range_bad || f3_bad || misalign;

    byte_en = 4'b0000;
    wlane   = wdata_p0;
    case (funct3_p0[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_p0[1:0];
        wlane   = {4{wdata_p0[7:0]}};
      end
      2'b01: begin
        byte_en = addr_p0[1] ? 4'b1100 : 4'b0011;
        wlane   = {2{wdata_p0[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wlane   = wdata_p0;
      end
    endcase
  end

  // Storage write at ACCESS -> RESP; reset in ACCESS cancels the write and
  // storage itself is never cleared.
  always_ff @(posedge clk) begin
    if (!rst && state == ACCESS && wren_p0 && !access_fault) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[idx][8*k +: 8] <= wlane[8*k +: 8];
      end
    end
  end

  // Control FSM and response registers (ACCESS -> RESP -> IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fault_p1 <= 1'b0;
      rdata_o  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) state <= ACCESS;
        ACCESS: begin
          state    <= RESP;
          fault_p1 <= access_fault;
          rdata_o  <= (ren_p0 && !access_fault)
                      ? load_extend(word_rd, funct3_p0, addr_p0[1:0]) : '0;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: a vector table of single requests with
// hand-computed results, followed by hand-written sequences for back-to-back
// requests and reset during ACCESS and RESP.
module tb_lsu_dmem;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        memren_i;
  logic        memwren_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rdata_o;
  logic        fault_o;
  logic        busy_o;

  int n_vec  = 0;
  int n_fail = 0;

  lsu_dmem dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .memren_i    (memren_i),
    .memwren_i   (memwren_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rdata_o     (rdata_o),
    .fault_o     (fault_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        ren;
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_f;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic void addv(input string nm, input logic ren, input logic wren,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] exp_d,
                               input logic exp_f);
    vec_t v;
    v.nm = nm; v.ren = ren; v.wren = wren; v.f3 = f3; v.addr = addr;
    v.wd = wd; v.exp_d = exp_d; v.exp_f = exp_f;
    vecs.push_back(v);
  endfunction

  // One complete request: drive in the IDLE cycle, then check ACCESS and RESP.
  task automatic do_req(input string nm, input logic ren, input logic wren,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_d,
                        input logic exp_f);
    @(negedge clk);
    check({nm, " ready"}, {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; memren_i = ren; memwren_i = wren;
    funct3_i = f3; addr_i = addr; wdata_i = wd;
    @(negedge clk);
    // Unaccepted store-like garbage: must be ignored while busy.
    req_valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b1;
    funct3_i = 3'd2; addr_i = 32'h0100_0010; wdata_i = 32'hFFFF_FFFF;
    check({nm, " busy"}, {31'd0, busy_o}, 32'd1);
    check({nm, " rsp_early"}, {31'd0, rsp_valid_o}, 32'd0);
    @(negedge clk);
    check({nm, " rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
    check({nm, " rdata"}, rdata_o, exp_d);
    check({nm, " fault"}, {31'd0, fault_o}, {31'd0, exp_f});
  endtask

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;
  localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

  logic [31:0] b_addr [9];
  logic [2:0]  b_f3   [9];
  logic        b_ren  [9];
  logic [31:0] b_exp  [9];
  int          acc_cnt;
  int          rsp_cnt;
  int          last_acc;

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0;
    funct3_i = 3'd0; addr_i = '0; wdata_i = '0;

    addv("sw_base",    0, 1, SW,  32'h0100_0010, 32'hDEAD_BEEF, 32'h0,          0);
    addv("lw_base",    1, 0, LW,  32'h0100_0010, 32'h0,         32'hDEAD_BEEF,  0);
    addv("sb_80",      0, 1, SB,  32'h0100_0011, 32'h1234_5680, 32'h0,          0);
    addv("lb_80",      1, 0, LB,  32'h0100_0011, 32'h0,         32'hFFFF_FF80,  0);
    addv("lbu_80",     1, 0, LBU, 32'h0100_0011, 32'h0,         32'h0000_0080,  0);
    addv("lw_merge",   1, 0, LW,  32'h0100_0010, 32'h0,         32'hDEAD_80EF,  0);
    addv("lh_lo",      1, 0, LH,  32'h0100_0010, 32'h0,         32'hFFFF_80EF,  0);
    addv("lh_hi",      1, 0, LH,  32'h0100_0012, 32'h0,         32'hFFFF_DEAD,  0);
    addv("lhu_hi",     1, 0, LHU, 32'h0100_0012, 32'h0,         32'h0000_DEAD,  0);
    addv("lb_lane0",   1, 0, LB,  32'h0100_0010, 32'h0,         32'hFFFF_FFEF,  0);
    addv("lbu_lane3",  1, 0, LBU, 32'h0100_0013, 32'h0,         32'h0000_00DE,  0);
    addv("sw_clr14",   0, 1, SW,  32'h0100_0014, 32'h0,         32'h0,          0);
    addv("sh_hi",      0, 1, SH,  32'h0100_0016, 32'hAAAA_7FFF, 32'h0,          0);
    addv("lw_sh",      1, 0, LW,  32'h0100_0014, 32'h0,         32'h7FFF_0000,  0);
    addv("lh_pos",     1, 0, LH,  32'h0100_0016, 32'h0,         32'h0000_7FFF,  0);
    addv("sw_last",    0, 1, SW,  32'h0100_0FFC, 32'hCAFE_F00D, 32'h0,          0);
    addv("lw_last",    1, 0, LW,  32'h0100_0FFC, 32'h0,         32'hCAFE_F00D,  0);
    addv("lh_misal",   1, 0, LH,  32'h0100_0011, 32'h0,         32'h0,          1);
    addv("sw_misal",   0, 1, SW,  32'h0100_0012, 32'h1111_1111, 32'h0,          1);
    addv("sh_misal",   0, 1, SH,  32'h0100_0011, 32'h3333_3333, 32'h0,          1);
    addv("lw_below",   1, 0, LW,  32'h00FF_FFFC, 32'h0,         32'h0,          1);
    addv("lw_above",   1, 0, LW,  32'h0100_1000, 32'h0,         32'h0,          1);
    addv("both_set",   1, 1, SW,  32'h0100_0010, 32'h2222_2222, 32'h0,          1);
    addv("neither",    0, 0, LW,  32'h0100_0010, 32'h0,         32'h0,          1);
    addv("ld_f3_3",    1, 0, 3'd3, 32'h0100_0010, 32'h0,        32'h0,          1);
    addv("st_f3_4",    0, 1, 3'd4, 32'h0100_0010, 32'h4444_4444, 32'h0,         1);
    addv("lw_intact",  1, 0, LW,  32'h0100_0010, 32'h0,         32'hDEAD_80EF,  0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst ready", {31'd0, req_ready_o}, 32'd1);
    check("rst rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst fault", {31'd0, fault_o}, 32'd0);
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst rdata", rdata_o, 32'd0);

    foreach (vecs[i])
      do_req(vecs[i].nm, vecs[i].ren, vecs[i].wren, vecs[i].f3, vecs[i].addr,
             vecs[i].wd, vecs[i].exp_d, vecs[i].exp_f);

    // Valid held for 9 cycles with a different request each cycle; only
    // cycles 0, 3 and 6 may be accepted. The rest are stores that would
    // corrupt 0x0100_0010 if taken.
    for (int i = 0; i < 9; i++) begin
      b_ren[i] = 1'b0; b_f3[i] = SW; b_addr[i] = 32'h0100_0010; b_exp[i] = 32'h0;
    end
    b_ren[0] = 1'b1; b_f3[0] = LW;  b_addr[0] = 32'h0100_0010; b_exp[0] = 32'hDEAD_80EF;
    b_ren[3] = 1'b1; b_f3[3] = LW;  b_addr[3] = 32'h0100_0014; b_exp[3] = 32'h7FFF_0000;
    b_ren[6] = 1'b1; b_f3[6] = LHU; b_addr[6] = 32'h0100_0FFE; b_exp[6] = 32'h0000_CAFE;
    acc_cnt = 0; rsp_cnt = 0; last_acc = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i < 9) begin
        req_valid_i = 1'b1; memren_i = b_ren[i]; memwren_i = !b_ren[i];
        funct3_i = b_f3[i]; addr_i = b_addr[i]; wdata_i = 32'hBAD0_0000 + i;
      end else begin
        req_valid_i = 1'b0;
      end
      check($sformatf("burst ready c%0d", i), {31'd0, req_ready_o},
            {31'd0, (i >= 9) || (i % 3 == 0)});
      check($sformatf("burst rsp c%0d", i), {31'd0, rsp_valid_o},
            {31'd0, (i <= 8) && (i % 3 == 2)});
      if (rsp_valid_o) begin
        rsp_cnt++;
        check($sformatf("burst rdata c%0d", i), rdata_o, b_exp[last_acc]);
      end
      if (req_valid_i && req_ready_o) begin
        acc_cnt++;
        last_acc = i;
      end
    end
    check("burst accepts", acc_cnt, 32'd3);
    check("burst responses", rsp_cnt, 32'd3);
    do_req("lw_after_burst", 1, 0, LW, 32'h0100_0010, 32'h0, 32'hDEAD_80EF, 0);

    // Reset during ACCESS of a store: no response, storage untouched.
    do_req("sw_prior", 0, 1, SW, 32'h0100_0020, 32'h0BAD_CAFE, 32'h0, 0);
    @(negedge clk);
    req_valid_i = 1'b1; memren_i = 1'b0; memwren_i = 1'b1;
    funct3_i = SW; addr_i = 32'h0100_0020; wdata_i = 32'h1234_5678;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("rstacc in_access", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstacc rsp", {31'd0, rsp_valid_o}, 32'd0);
    check("rstacc ready", {31'd0, req_ready_o}, 32'd1);
    check("rstacc busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check("rstacc rsp_late", {31'd0, rsp_valid_o}, 32'd0);
    do_req("lw_prior", 1, 0, LW, 32'h0100_0020, 32'h0, 32'h0BAD_CAFE, 0);

    // Reset while a load sits in RESP.
    @(negedge clk);
    req_valid_i = 1'b1; memren_i = 1'b1; memwren_i = 1'b0;
    funct3_i = LW; addr_i = 32'h0100_0010; wdata_i = 32'h0;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    check("rstrsp rsp_before", {31'd0, rsp_valid_o}, 32'd1);
    check("rstrsp rdata_before", rdata_o, 32'hDEAD_80EF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstrsp rsp", {31'd0, rsp_valid_o}, 32'd0);
    check("rstrsp fault", {31'd0, fault_o}, 32'd0);
    check("rstrsp rdata", rdata_o, 32'd0);
    check("rstrsp ready", {31'd0, req_ready_o}, 32'd1);

    // A faulting response followed by a normal one: fault must not linger.
    do_req("lw_flt_again", 1, 0, LW, 32'h0100_0013, 32'h0, 32'h0, 1);
    do_req("lw_ok_again", 1, 0, LW, 32'h0100_0014, 32'h0, 32'h7FFF_0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_dmem.md
LSU_DMEM -- requirements
Module: lsu_dmem

Interface
REQ-001 Parameter DWIDTH, default 32: data and address width.
REQ-002 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in internal storage.
REQ-003 Parameter BASE_ADDR, default 32'h0100_0000: byte address of word 0.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk in 1 rising-edge clock; rst in 1 synchronous active-high reset.
REQ-005 req_valid_i in 1: request present.
REQ-006 req_ready_o out 1: block can accept a request.
REQ-007 memren_i in 1: load request (decode control bit).
REQ-008 memwren_i in 1: store request (decode control bit).
REQ-009 funct3_i in 3: access size/sign (RV32I load/store funct3).
REQ-010 addr_i in DWIDTH: byte address (ALU result).
REQ-011 wdata_i in DWIDTH: store data (rs2), low bytes used for SB/SH.
REQ-012 rsp_valid_o out 1: one-cycle response strobe.
REQ-013 rdata_o out DWIDTH: load result, extended to 32 bits.
REQ-014 fault_o out 1: request rejected (qualified by rsp_valid_o).
REQ-015 busy_o out 1: request in flight (state != IDLE).

Function
REQ-016 The block SHALL be an FSM with states IDLE, ACCESS, RESP; req_ready_o = 1 only in IDLE.
REQ-017 Accept = req_valid_i && req_ready_o; on accept, memren_i, memwren_i, funct3_i, addr_i and wdata_i SHALL be registered, and the state SHALL go IDLE->ACCESS.
REQ-018 ACCESS->RESP and RESP->IDLE SHALL be unconditional, so rsp_valid_o rises exactly 2 cycles after the accept edge, and throughput is 1 request per 3 cycles.
REQ-019 Inputs SHALL be ignored when no accept occurs.
REQ-020 Word index = (addr - BASE_ADDR) >> 2. If addr < BASE_ADDR or index >= DEPTH_WORDS, the request SHALL fault.
REQ-021 The following SHALL fault:
- memren_i == memwren_i (both or neither set);
- load funct3 not in {0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU};
- store funct3 not in {0 SB, 1 SH, 2 SW}.
REQ-022 Misalignment SHALL fault: halfword with addr[0]=1; word with addr[1:0]!=0. Byte accesses are never misaligned.
REQ-023 Storage is little-endian. A non-faulting store SHALL write only the addressed byte lanes at the ACCESS->RESP edge.
- SB: lane addr[1:0] <= wdata[7:0].
- SH: lanes addr[1]*2 and +1 <= wdata[15:0].
- SW: all lanes.
REQ-024 A faulting store SHALL leave storage unchanged.
REQ-025 A non-faulting load SHALL select the addressed byte/halfword and extend it:
- LB/LH sign-extend.
- LBU/LHU zero-extend.
- LW passes the word unchanged.
The result SHALL be registered into rdata_o at the ACCESS->RESP edge.
REQ-026 In RESP: rsp_valid_o = 1 for exactly one cycle. rdata_o = load result, or 0 for stores and faults. fault_o per REQ-020..022. Outside RESP, rsp_valid_o and fault_o SHALL be 0; rdata_o SHALL hold its last value.
REQ-027 A store followed by a load to the same address SHALL return the stored data, because the write completes before the next accept is possible.

Reset
REQ-028 On a rising edge with rst=1, the state SHALL go to IDLE, and rsp_valid_o, fault_o, rdata_o and busy_o SHALL go to 0; req_ready_o SHALL be 1 in the following cycle.
REQ-029 rst takes priority over all transitions. Reset asserted in ACCESS SHALL suppress that cycle's store write and abandon the request with no response.
REQ-030 Storage contents SHALL NOT be affected by reset.

Verification
REQ-031 SW to 0x0100_0010, data 0xDEADBEEF, then LW at the same address -> rsp_valid_o 2 cycles after each accept; LW rdata_o=0xDEADBEEF, fault_o=0.
REQ-032 Following REQ-031, SB 0x80 to 0x0100_0011, then:
- LB 0x0100_0011 -> 0xFFFFFF80;
- LBU -> 0x00000080;
- LW 0x0100_0010 -> 0xDEAD80EF.
REQ-033 Each of the following SHALL give fault_o=1, rdata_o=0, and leave the word unchanged:
- LH 0x0100_0011;
- SW 0x0100_0012;
- LW 0x00FF_FFFC;
- LW at BASE_ADDR+4*DEPTH_WORDS;
- memren_i=memwren_i=1;
- load funct3=3.
REQ-034 req_valid_i held high for 9 cycles with distinct requests -> exactly 3 accepts; req_ready_o pattern 1,0,0 repeating; one response per accept.
REQ-035 SW 0x0100_0020 data 0x12345678 with rst asserted in the ACCESS cycle -> no rsp_valid_o; the word keeps its prior value; an LW issued after reset returns the prior value.
REQ-036 Reset with a load in RESP -> rsp_valid_o, fault_o and rdata_o are 0 and req_ready_o is 1 on the next cycle.
